// File: rtl/ascon_inv_sbox_layer.sv
`default_nettype none
// ============================================================================
// Module      : ascon_inv_sbox_layer
// Description : Inverse ASCON 5-bit S-box layer over the 320-bit state,
//               LANES bit-columns per cycle (64/LANES cycles per state),
//               valid/ready on both sides. Optional self-check enabled by
//               macro ASCON_INV_SBOX_SELFCHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_inv_sbox_layer #(
    parameter int LANES = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [319:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] state_out,
    output logic         chk_err
);

    localparam int K  = 64 / LANES;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    // Inverse S-box table, entry y at bits [5*y +: 5]
    localparam logic [159:0] c_INV_LUT = {
        5'd2,  5'd16, 5'd12, 5'd15, 5'd8,  5'd4,  5'd27, 5'd23,
        5'd31, 5'd28, 5'd5,  5'd3,  5'd17, 5'd11, 5'd22, 5'd24,
        5'd30, 5'd19, 5'd21, 5'd25, 5'd1,  5'd29, 5'd6,  5'd10,
        5'd18, 5'd14, 5'd9,  5'd0,  5'd13, 5'd7,  5'd26, 5'd20
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [319:0]    r_work;
    logic [319:0]    w_work_nxt;
    logic [5*LANES-1:0] w_pre_flat;  // column j at [5*j +: 5], x0 as MSB
    logic [5*LANES-1:0] w_sub_flat;  // substituted columns, same packing
    logic [5*LANES-1:0] w_lo_sub;    // word k low bits at [k*LANES +: LANES]
    logic            w_last;

    assign w_last = (r_cnt == CW'(K - 1));

    // Gather the low LANES columns and substitute them
    generate
        for (genvar j = 0; j < LANES; j++) begin : g_col
            assign w_pre_flat[5*j +: 5] = {r_work[256+j], r_work[192+j],
                                           r_work[128+j], r_work[64+j], r_work[j]};
            assign w_sub_flat[5*j +: 5] = c_INV_LUT[5*w_pre_flat[5*j +: 5] +: 5];
        end
    endgenerate

    // Scatter substituted columns back and rotate each word right by LANES,
    // so after K cycles every column has been processed and alignment restored
    generate
        for (genvar k = 0; k < 5; k++) begin : g_word
            localparam int B = 64 * (4 - k);
            for (genvar j = 0; j < LANES; j++) begin : g_bit
                assign w_lo_sub[k*LANES + j] = w_sub_flat[5*j + (4 - k)];
            end
            if (LANES == 64) begin : g_full
                assign w_work_nxt[B +: 64] = w_lo_sub[k*LANES +: LANES];
            end else begin : g_rot
                assign w_work_nxt[B +: 64] = {w_lo_sub[k*LANES +: LANES],
                                              r_work[B+LANES +: 64-LANES]};
            end
        end
    endgenerate

    // Next-state logic and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign state_out = (r_state == S_DONE) ? r_work : 320'd0;

    // State register, work register and cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work <= state_in;
                        r_cnt  <= '0;
                    end
                end
                S_BUSY: begin
                    r_work <= w_work_nxt;
                    r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ASCON_INV_SBOX_SELFCHECK_EN
    // Forward S-box table, entry y at bits [5*y +: 5]
    localparam logic [159:0] c_FWD_LUT = {
        5'd23, 5'd15, 5'd10, 5'd22, 5'd25, 5'd1,  5'd12, 5'd16,
        5'd24, 5'd17, 5'd13, 5'd0,  5'd14, 5'd7,  5'd19, 5'd30,
        5'd28, 5'd6,  5'd3,  5'd29, 5'd18, 5'd8,  5'd5,  5'd27,
        5'd2,  5'd9,  5'd21, 5'd26, 5'd20, 5'd31, 5'd11, 5'd4
    };

    logic [LANES-1:0] w_mis;
    logic             r_chk_err;

    generate
        for (genvar j = 0; j < LANES; j++) begin : g_chk
            assign w_mis[j] = (c_FWD_LUT[5*w_sub_flat[5*j +: 5] +: 5] != w_pre_flat[5*j +: 5]);
        end
    endgenerate

    // Sticky error: forward map of each substituted column must give back its input
    always_ff @(posedge clk) begin
        if (rst)                                r_chk_err <= 1'b0;
        else if ((r_state == S_BUSY) && |w_mis) r_chk_err <= 1'b1;
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ascon_inv_sbox_layer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascon_inv_sbox_layer
// Description : Self-checking bench; three instances (LANES = 1, 8, 64) share
//               the input side and are compared with a column-wise table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascon_inv_sbox_layer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [319:0] state_in;
    logic         out_ready;
    logic         in_ready  [3];
    logic         out_valid [3];
    logic [319:0] state_out [3];
    logic         chk_err   [3];

    int n_tests = 0;
    int n_fail  = 0;

    int LAT_EXP [3] = '{64, 8, 1};

    int SB  [32] = '{4,11,31,20,26,21,9,2,27,5,8,18,29,3,6,28,
                     30,19,7,14,0,13,17,24,16,12,1,25,22,10,15,23};
    int INV [32] = '{20,26,7,13,0,9,14,18,10,6,29,1,25,21,19,30,
                     24,22,11,17,3,5,28,31,23,27,4,8,15,12,16,2};

    always #5 clk = ~clk;

    ascon_inv_sbox_layer #(.LANES(1)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .state_in(state_in), .out_valid(out_valid[0]), .out_ready(out_ready),
        .state_out(state_out[0]), .chk_err(chk_err[0]));
    ascon_inv_sbox_layer #(.LANES(8)) u_l8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .state_in(state_in), .out_valid(out_valid[1]), .out_ready(out_ready),
        .state_out(state_out[1]), .chk_err(chk_err[1]));
    ascon_inv_sbox_layer #(.LANES(64)) u_l64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
        .state_in(state_in), .out_valid(out_valid[2]), .out_ready(out_ready),
        .state_out(state_out[2]), .chk_err(chk_err[2]));

    // Column-wise table substitution over the whole state
    function automatic logic [319:0] sub_layer(input logic [319:0] s, input bit inverse);
        logic [319:0] r;
        logic [4:0]   y, z;
        r = s;
        for (int i = 0; i < 64; i++) begin
            y = {s[256+i], s[192+i], s[128+i], s[64+i], s[i]};
            z = inverse ? 5'(INV[y]) : 5'(SB[y]);
            {r[256+i], r[192+i], r[128+i], r[64+i], r[i]} = z;
        end
        return r;
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_in_ready%0d", tag, d), 320'(in_ready[d]), 320'd1);
            chk($sformatf("%s_out_valid%0d", tag, d), 320'(out_valid[d]), 320'd0);
            chk($sformatf("%s_state_out%0d", tag, d), state_out[d], 320'd0);
            chk($sformatf("%s_chk_err%0d", tag, d), 320'(chk_err[d]), 320'd0);
        end
    endtask

    // Load one state into all instances, check latency/result, optionally hold DONE
    task automatic run_case(input string tag, input logic [319:0] s, input logic [319:0] exp,
                            input bit hold);
        int first [3];
        logic [319:0] snap [3];
        for (int d = 0; d < 3; d++) first[d] = -1;
        in_valid = 1'b1;
        state_in = s;
        tick();
        in_valid = 1'b0;
        state_in = rand_state();
        for (int c = 1; c <= 80; c++) begin
            tick();
            for (int d = 0; d < 3; d++)
                if (out_valid[d] && first[d] < 0) first[d] = c;
            if (first[0] >= 0 && first[1] >= 0 && first[2] >= 0) break;
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_latency%0d", tag, d), 320'(first[d]), 320'(LAT_EXP[d]));
            chk($sformatf("%s_data%0d", tag, d), state_out[d], exp);
            snap[d] = state_out[d];
        end
        if (hold) begin
            for (int c = 0; c < 5; c++) begin
                in_valid = c[0];
                state_in = rand_state();
                tick();
                for (int d = 0; d < 3; d++) begin
                    chk($sformatf("%s_hold_data%0d", tag, d), state_out[d], snap[d]);
                    chk($sformatf("%s_hold_inrdy%0d", tag, d), 320'(in_ready[d]), 320'd0);
                    chk($sformatf("%s_hold_oval%0d", tag, d), 320'(out_valid[d]), 320'd1);
                end
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_idle({tag, "_release"});
    endtask

    initial begin
        logic [319:0] orig;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_idle("reset");

        // Known vectors: all-zero -> x0=x2=ones; all-ones -> x3=ones
        run_case("zero", 320'd0, {64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0}, 1'b0);
        chk("zero_model", sub_layer(320'd0, 1'b1),
            {64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0});
        run_case("ones", {320{1'b1}}, {64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0}, 1'b0);

        // Round trip: forward layer then the block must give back the original
        for (int t = 0; t < 4; t++) begin
            orig = rand_state();
            run_case($sformatf("rand%0d", t), sub_layer(orig, 1'b0), orig, 1'b0);
        end

        // Random direct inverse with DONE held under back-pressure
        orig = rand_state();
        run_case("hold", orig, sub_layer(orig, 1'b1), 1'b1);

        // Reset in the middle of BUSY (LANES=8 at cnt=3)
        in_valid = 1'b1;
        state_in = rand_state();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("midrst");
        orig = rand_state();
        run_case("after_rst", sub_layer(orig, 1'b0), orig, 1'b0);

`ifdef ASCON_INV_SBOX_SELFCHECK_EN
        // Corrupt the substituted columns for one BUSY cycle
        in_valid = 1'b1;
        state_in = 320'd0;
        tick();
        in_valid = 1'b0;
        tick();
        force u_l8.w_sub_flat = '1;
        tick();
        release u_l8.w_sub_flat;
        chk("selfchk_set", 320'(chk_err[1]), 320'd1);
        for (int c = 0; c < 10; c++) tick();
        chk("selfchk_sticky", 320'(chk_err[1]), 320'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("selfchk_clr", 320'(chk_err[1]), 320'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
